// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit_if
// Description : Bus bundle for the instruction-fetch stage. It groups the
//               hazard, EX-resolution, instruction-memory and IF/ID signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_if;
  logic [31:0] instr_if;
  logic        predicted_taken_if;
  logic [31:0] predicted_target_if;

  // The fetch unit side
  modport master (
    input  stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  imem_rdata,
    output imem_addr, pc_if, instr_if, predicted_taken_if, predicted_target_if
  );

  // The pipeline / memory / hazard side
  modport slave (
    output stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output imem_rdata,
    input  imem_addr, pc_if, instr_if, predicted_taken_if, predicted_target_if
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage: PC register, instruction-memory
//               address and a direct-mapped BTB with 2-bit counters.
//               The BTB is built only when IF_FETCH_BTB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  if_fetch_unit_if.master    bus
);

  localparam int IDX_W = (BTB_ENTRIES > 1) ? $clog2(BTB_ENTRIES) : 1;
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;

`ifdef IF_FETCH_BTB_EN
  logic             r_btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] r_btb_tag    [BTB_ENTRIES];
  logic [29:0]      r_btb_target [BTB_ENTRIES];
  logic [1:0]       r_btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic             w_hit;
  logic             w_upd_hit;
  logic [3:0]       w_unused;

  assign w_idx     = r_pc[IDX_W+1:2];
  assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
  assign w_hit     = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == r_pc[31:IDX_W+2]);
  assign w_upd_hit = r_btb_valid[w_upd_idx] &&
                     (r_btb_tag[w_upd_idx] == bus.upd_pc[31:IDX_W+2]);

  assign w_pred_taken  = w_hit && r_btb_ctr[w_idx][1];
  assign w_pred_target = w_pred_taken ? {r_btb_target[w_idx], 2'b00} : 32'h0;

  // Lookup reads the array before this edge, so a same-index update shows next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb_valid[i]  <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= '0;
        r_btb_ctr[i]    <= 2'b01;
      end
    end else if (bus.upd_valid) begin
      if (w_upd_hit) begin
        if (bus.upd_taken) begin
          if (r_btb_ctr[w_upd_idx] != 2'b11)
            r_btb_ctr[w_upd_idx] <= r_btb_ctr[w_upd_idx] + 2'b01;
          r_btb_target[w_upd_idx] <= bus.upd_target[31:2];
        end else if (r_btb_ctr[w_upd_idx] != 2'b00) begin
          r_btb_ctr[w_upd_idx] <= r_btb_ctr[w_upd_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        r_btb_valid[w_upd_idx]  <= 1'b1;
        r_btb_tag[w_upd_idx]    <= bus.upd_pc[31:IDX_W+2];
        r_btb_target[w_upd_idx] <= bus.upd_target[31:2];
        r_btb_ctr[w_upd_idx]    <= 2'b10;
      end
    end
  end

  assign w_unused = {bus.upd_pc[1:0], bus.upd_target[1:0]};
`else
  logic [70:0] w_unused;

  assign w_pred_taken  = 1'b0;
  assign w_pred_target = 32'h0;
  assign w_unused      = {bus.upd_valid, bus.upd_pc, bus.upd_taken, bus.upd_target,
                          bus.redirect_pc[1:0]};
`endif

  // Redirect outranks stall so a mispredict can land while decode is frozen
  always_comb begin
    w_pc_next = r_pc + 32'd4;
    if (bus.redirect_valid)
      w_pc_next = {bus.redirect_pc[31:2], 2'b00};
    else if (bus.stall)
      w_pc_next = r_pc;
    else if (w_pred_taken)
      w_pc_next = w_pred_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pc <= RESET_PC;
    else
      r_pc <= w_pc_next;
  end

  assign bus.imem_addr           = r_pc;
  assign bus.pc_if               = r_pc;
  assign bus.instr_if            = bus.imem_rdata;
  assign bus.predicted_taken_if  = w_pred_taken;
  assign bus.predicted_target_if = w_pred_target;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit; BTB checks
//               are selected by IF_FETCH_BTB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC    (32'h0000_0100),
    .BTB_ENTRIES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Asynchronous instruction memory: word = bitwise inverse of address
  assign bus.imem_rdata = ~bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] addr);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = addr;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic upd_set(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
  endtask

  task automatic pred(input string tag, input logic tk, input logic [31:0] tgt);
    chk({tag, "_taken"},  {31'b0, bus.predicted_taken_if}, {31'b0, tk});
    chk({tag, "_target"}, bus.predicted_target_if, tgt);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = 32'h0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = 32'h0;

    #12;
    chk("rst_pc", bus.pc_if, 32'h100);
    chk("rst_addr", bus.imem_addr, 32'h100);
    pred("rst", 1'b0, 32'h0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("run_pc0", bus.pc_if, 32'h100);
    chk("run_instr0", bus.instr_if, ~32'h100);
    step(); chk("run_pc1", bus.pc_if, 32'h104); pred("run1", 1'b0, 32'h0);
    step(); chk("run_pc2", bus.pc_if, 32'h108); pred("run2", 1'b0, 32'h0);
    step(); chk("run_pc3", bus.pc_if, 32'h10C); pred("run3", 1'b0, 32'h0);

`ifdef IF_FETCH_BTB_EN
    // Allocate 0x110 -> 0x200 while fetching 0x10C
    upd_set(32'h110, 1'b1, 32'h200);
    step();
    bus.upd_valid = 1'b0;
    chk("alloc_pc", bus.pc_if, 32'h110);
    pred("alloc", 1'b1, 32'h200);
    step(); chk("alloc_next", bus.pc_if, 32'h200);

    // Two not-taken updates: ctr 2 -> 1 -> 0
    upd_set(32'h110, 1'b0, 32'h0);
    step(); step();
    bus.upd_valid = 1'b0;
    redir(32'h110);
    pred("ctr0", 1'b0, 32'h0);
    step(); chk("ctr0_next", bus.pc_if, 32'h114);

    // One taken update: ctr 0 -> 1, still not taken
    upd_set(32'h110, 1'b1, 32'h200);
    step();
    bus.upd_valid = 1'b0;
    redir(32'h110);
    pred("ctr1", 1'b0, 32'h0);

    // Second taken update issued while fetching 0x110: ctr 1 -> 2
    upd_set(32'h110, 1'b1, 32'h200);
    step();
    bus.upd_valid = 1'b0;
    chk("ctr1_next", bus.pc_if, 32'h114);
    redir(32'h110);
    pred("ctr2", 1'b1, 32'h200);

    // Alias: 0x150 shares index 4 with 0x110
    upd_set(32'h150, 1'b1, 32'h400);
    step();
    bus.upd_valid = 1'b0;
    redir(32'h110);
    pred("alias_old", 1'b0, 32'h0);
    step(); chk("alias_old_next", bus.pc_if, 32'h114);
    redir(32'h150);
    pred("alias_new", 1'b1, 32'h400);
    step(); chk("alias_new_next", bus.pc_if, 32'h400);

    // Same-cycle lookup and allocating update at 0x130
    redir(32'h130);
    upd_set(32'h130, 1'b1, 32'h500);
    pred("same_cyc", 1'b0, 32'h0);
    step();
    bus.upd_valid = 1'b0;
    chk("same_cyc_next", bus.pc_if, 32'h134);
    redir(32'h130);
    pred("same_refetch", 1'b1, 32'h500);
`else
    // Updates are ignored without a BTB
    upd_set(32'h110, 1'b1, 32'h200);
    step();
    bus.upd_valid = 1'b0;
    chk("nobtb_pc", bus.pc_if, 32'h110);
    pred("nobtb", 1'b0, 32'h0);
    step(); chk("nobtb_next", bus.pc_if, 32'h114);
`endif

    // Stall holds the PC; redirect wins during stall, low bits cleared
    redir(32'h120);
    chk("stall_pc0", bus.pc_if, 32'h120);
    bus.stall = 1'b1;
    step(); chk("stall_pc1", bus.pc_if, 32'h120);
    step(); chk("stall_pc2", bus.pc_if, 32'h120);
    step(); chk("stall_pc3", bus.pc_if, 32'h120);
    redir(32'h303);
    chk("stall_redir", bus.pc_if, 32'h300);
    chk("stall_redir_instr", bus.instr_if, ~32'h300);
    step(); chk("stall_after", bus.pc_if, 32'h300);
    bus.stall = 1'b0;
    step(); chk("unstall", bus.pc_if, 32'h304);

    // Mid-stream asynchronous reset
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", bus.pc_if, 32'h100);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_pc", bus.pc_if, 32'h100);
    step(); chk("post_rst_pc1", bus.pc_if, 32'h104);
`ifdef IF_FETCH_BTB_EN
    redir(32'h130); pred("rst_inv130", 1'b0, 32'h0);
    redir(32'h150); pred("rst_inv150", 1'b0, 32'h0);
    redir(32'h110); pred("rst_inv110", 1'b0, 32'h0);
`endif

    // 32-bit wrap of PC+4
    redir(32'hFFFF_FFFC);
    chk("wrap_pc0", bus.pc_if, 32'hFFFF_FFFC);
    step(); chk("wrap_pc1", bus.pc_if, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
